// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - format codes, field positions, buffer states and result type for imm_extend_unit
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I  = 3'd0,
        FMT_D  = 3'd1,
        FMT_B  = 3'd2,
        FMT_CB = 3'd3,
        FMT_IW = 3'd4
    } fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    localparam int IMM_MAX_W = 64;

    localparam int I_LSB  = 10;
    localparam int I_W    = 12;
    localparam int D_LSB  = 12;
    localparam int D_W    = 9;
    localparam int B_LSB  = 0;
    localparam int B_W    = 26;
    localparam int CB_LSB = 5;
    localparam int CB_W   = 19;
    localparam int IW_LSB = 5;
    localparam int IW_W   = 16;
    localparam int HW_LSB = 21;
    localparam int HW_W   = 2;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic                 err;
    } imm_res_t;

endpackage

// File: rtl/imm_skid_buffer.sv
// rtl/imm_skid_buffer.sv - generic 2-entry valid/ready skid buffer with registered ready
module imm_skid_buffer
    import imm_pkg::*;
#(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic [W-1:0] s_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata
);

    buf_state_e   state, state_n;
    logic [W-1:0] main_q, main_n;
    logic [W-1:0] skid_q, skid_n;
    logic         ready_q, ready_n;
    logic         accept, pop;

    // ready is a flop; the reset gate only holds it low while reset is applied
    assign s_tready = ready_q && !reset;
    assign m_tvalid = (state != BUF_EMPTY);
    assign m_tdata  = main_q;
    assign accept   = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    main_n  = s_tdata;
                    state_n = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && !pop) begin
                    skid_n  = s_tdata;
                    state_n = BUF_TWO;
                end else if (accept && pop) begin
                    main_n = s_tdata;
                end else if (pop) begin
                    state_n = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    main_n  = skid_q;
                    state_n = BUF_ONE;
                end
            end
            default: state_n = BUF_EMPTY;
        endcase
        ready_n = (state_n != BUF_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
            ready_q <= ready_n;
        end
    end

endmodule

// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - immediate extract/extend to DATA_W with skid-buffered output; BRANCH_SCALE_EN scales B/CB by 4
module imm_extend_unit
    import imm_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [2:0]        in_fmt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_err
);

    logic [I_W-1:0]       f_i;
    logic [D_W-1:0]       f_d;
    logic [B_W-1:0]       f_b;
    logic [CB_W-1:0]      f_cb;
    logic [IW_W-1:0]      f_iw;
    logic [HW_W-1:0]      hw;
    logic [6:0]           iw_top;
    logic [IMM_MAX_W-1:0] b_sext, cb_sext, b_ext, cb_ext;
    imm_res_t             res;
    logic [DATA_W:0]      enc, dec;
    logic                 unused_instr;

    assign f_i  = in_instr[I_LSB +: I_W];
    assign f_d  = in_instr[D_LSB +: D_W];
    assign f_b  = in_instr[B_LSB +: B_W];
    assign f_cb = in_instr[CB_LSB +: CB_W];
    assign f_iw = in_instr[IW_LSB +: IW_W];
    assign hw   = in_instr[HW_LSB +: HW_W];
    assign unused_instr = ^in_instr[31:26];

    // highest bit position + 1 that the shifted IW halfword would occupy
    assign iw_top = {1'b0, hw, 4'b0000} + 7'd16;

    // extension is done at 64 bits; truncating afterwards is exact for DATA_W=32
    assign b_sext  = {{(IMM_MAX_W-B_W){f_b[B_W-1]}}, f_b};
    assign cb_sext = {{(IMM_MAX_W-CB_W){f_cb[CB_W-1]}}, f_cb};

`ifdef BRANCH_SCALE_EN
    assign b_ext  = b_sext << 2;
    assign cb_ext = cb_sext << 2;
`else
    assign b_ext  = b_sext;
    assign cb_ext = cb_sext;
`endif

    always_comb begin
        res = '0;
        case (in_fmt)
            FMT_I:  res.imm = {{(IMM_MAX_W-I_W){1'b0}}, f_i};
            FMT_D:  res.imm = {{(IMM_MAX_W-D_W){f_d[D_W-1]}}, f_d};
            FMT_B:  res.imm = b_ext;
            FMT_CB: res.imm = cb_ext;
            FMT_IW: begin
                if (iw_top > 7'(DATA_W)) begin
                    res.err = 1'b1;
                end else begin
                    res.imm = {{(IMM_MAX_W-IW_W){1'b0}}, f_iw} << {hw, 4'b0000};
                end
            end
            default: res.err = 1'b1;
        endcase
    end

    assign enc = {res.err, res.imm[DATA_W-1:0]};

    generate
        if (DATA_W < IMM_MAX_W) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^res.imm[IMM_MAX_W-1:DATA_W];
        end
    endgenerate

    imm_skid_buffer #(.W(DATA_W + 1)) u_buf (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (in_valid),
        .s_tready (in_ready),
        .s_tdata  (enc),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .m_tdata  (dec)
    );

    assign out_err = dec[DATA_W];
    assign out_imm = dec[DATA_W-1:0];

endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - self-checking bench for imm_extend_unit at DATA_W=64 and DATA_W=32
module tb_imm_extend_unit;

`ifdef BRANCH_SCALE_EN
    localparam bit SCALE = 1'b1;
`else
    localparam bit SCALE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic        rdy64, vld64, err64;
    logic        rdy32, vld32, err32;
    logic [63:0] imm64;
    logic [31:0] imm32;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] instr;
        logic [63:0] e64;
        logic        r64;
        logic [31:0] e32;
        logic        r32;
    } vec_t;

    vec_t        vecs[$];
    logic [64:0] q64[$];
    logic [64:0] q32[$];

    imm_extend_unit #(.DATA_W(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(vld64),
        .out_ready(out_ready), .out_imm(imm64), .out_err(err64)
    );

    imm_extend_unit #(.DATA_W(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(vld32),
        .out_ready(out_ready), .out_imm(imm32), .out_err(err32)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string n, input logic [63:0] e64, input logic r64,
                             input logic [31:0] e32, input logic r32);
        check({n, ".imm64"}, imm64, e64);
        check({n, ".err64"}, {63'b0, err64}, {63'b0, r64});
        check({n, ".imm32"}, {32'b0, imm32}, {32'b0, e32});
        check({n, ".err32"}, {63'b0, err32}, {63'b0, r32});
    endtask

    // reference: {err, imm} computed from the field rules with integer arithmetic
    function automatic logic [64:0] ref_model(input logic [31:0] instr, input logic [2:0] fmt, input int w);
        longint u, v;
        int     hw;
        bit     err;
        u   = longint'({32'b0, instr});
        v   = 0;
        err = 1'b0;
        case (fmt)
            3'd0: v = (u >> 10) & 64'hFFF;
            3'd1: begin
                v = (u >> 12) & 64'h1FF;
                if (v >= 256) v = v - 512;
            end
            3'd2: begin
                v = u & 64'h3FF_FFFF;
                if (v >= (longint'(1) << 25)) v = v - (longint'(1) << 26);
                if (SCALE) v = v * 4;
            end
            3'd3: begin
                v = (u >> 5) & 64'h7_FFFF;
                if (v >= (longint'(1) << 18)) v = v - (longint'(1) << 19);
                if (SCALE) v = v * 4;
            end
            3'd4: begin
                hw = int'((u >> 21) & 64'h3);
                v  = (u >> 5) & 64'hFFFF;
                if (16 * hw + 16 > w) begin
                    v   = 0;
                    err = 1'b1;
                end else begin
                    v = v * (longint'(1) << (16 * hw));
                end
            end
            default: err = 1'b1;
        endcase
        if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return {err, v};
    endfunction

    function automatic logic [31:0] mk(input int val);
        return 32'(val) << 10;
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_fmt    = '0;

        vecs.push_back('{3'd1, 32'h001FF000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'd1, 32'h000FF000, 64'h0000_0000_0000_00FF, 1'b0, 32'h0000_00FF, 1'b0});
        vecs.push_back('{3'd3, 32'hFF80001F,
                         SCALE ? 64'hFFFF_FFFF_FFF0_0000 : 64'hFFFF_FFFF_FFFC_0000, 1'b0,
                         SCALE ? 32'hFFF0_0000 : 32'hFFFC_0000, 1'b0});
        vecs.push_back('{3'd2, 32'h02000000,
                         SCALE ? 64'hFFFF_FFFF_F800_0000 : 64'hFFFF_FFFF_FE00_0000, 1'b0,
                         SCALE ? 32'hF800_0000 : 32'hFE00_0000, 1'b0});
        vecs.push_back('{3'd2, 32'hFC000001, SCALE ? 64'd4 : 64'd1, 1'b0, SCALE ? 32'd4 : 32'd1, 1'b0});
        vecs.push_back('{3'd0, 32'hFFFFFFFF, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0});
        vecs.push_back('{3'd4, 32'h0057DDE0, 64'h0000_BEEF_0000_0000, 1'b0, 32'h0, 1'b1});
        vecs.push_back('{3'd4, 32'h003FFFE0, 64'h0000_0000_FFFF_0000, 1'b0, 32'hFFFF_0000, 1'b0});
        vecs.push_back('{3'd4, 32'h00624680, 64'h1234_0000_0000_0000, 1'b0, 32'h0, 1'b1});
        vecs.push_back('{3'd4, 32'hFF81FFFF, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0});
        vecs.push_back('{3'd5, 32'hFFFFFFFF, 64'h0, 1'b1, 32'h0, 1'b1});
        vecs.push_back('{3'd6, 32'h12345678, 64'h0, 1'b1, 32'h0, 1'b1});
        vecs.push_back('{3'd7, 32'h0057DDE0, 64'h0, 1'b1, 32'h0, 1'b1});

        // reset state
        repeat (2) @(negedge clk);
        check("rst.valid64", {63'b0, vld64}, 64'd0);
        check("rst.valid32", {63'b0, vld32}, 64'd0);
        check_out("rst", 64'd0, 1'b0, 32'd0, 1'b0);
        check("rst.ready_held", {63'b0, rdy64}, 64'd0);
        reset = 1'b0;
        #1;
        check("rst.ready_release", {63'b0, rdy64}, 64'd1);

        // directed table, one item per cycle, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_fmt   = vecs[i].fmt;
            @(negedge clk);
            check($sformatf("vec%0d.valid", i), {62'b0, vld64, vld32}, 64'd3);
            check_out($sformatf("vec%0d", i), vecs[i].e64, vecs[i].r64, vecs[i].e32, vecs[i].r32);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("table.drain", {62'b0, vld64, vld32}, 64'd0);

        // A,B,C with the consumer stalled for three cycles
        in_fmt    = 3'd0;
        in_instr  = mk(1);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("abc.validA", {63'b0, vld64}, 64'd1);
        check("abc.A", imm64, 64'd1);
        check("abc.ready1", {63'b0, rdy64}, 64'd1);
        in_instr = mk(2);
        @(negedge clk);
        check("abc.full", {62'b0, rdy64, rdy32}, 64'd0);
        check("abc.holdA1", imm64, 64'd1);
        in_instr = mk(3);
        @(negedge clk);
        check("abc.stillfull", {63'b0, rdy64}, 64'd0);
        check("abc.holdA2", imm64, 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("abc.B", imm64, 64'd2);
        check("abc.readyB", {63'b0, rdy64}, 64'd1);
        @(negedge clk);
        check("abc.C", imm64, 64'd3);
        check("abc.validC", {63'b0, vld64}, 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        check("abc.drain", {63'b0, vld64}, 64'd0);

        // simultaneous accept and pop while holding one item
        in_valid = 1'b1;
        in_instr = mk(100);
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            in_instr = mk(100 + k);
            @(negedge clk);
            check($sformatf("one.ready%0d", k), {63'b0, rdy64}, 64'd1);
            check($sformatf("one.item%0d", k), imm64, 64'(100 + k));
            check($sformatf("one.item32_%0d", k), {32'b0, imm32}, 64'(100 + k));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("one.drain", {63'b0, vld64}, 64'd0);

        // reset while two items are held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = mk(200);
        @(negedge clk);
        in_instr = mk(201);
        @(negedge clk);
        check("rst2.full", {63'b0, rdy64}, 64'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("rst2.valid", {62'b0, vld64, vld32}, 64'd0);
        check("rst2.imm", imm64, 64'd0);
        check("rst2.ready_held", {63'b0, rdy64}, 64'd0);
        reset = 1'b0;
        #1;
        check("rst2.ready_release", {63'b0, rdy64}, 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst2.gone%0d", k), {62'b0, vld64, vld32}, 64'd0);
        end

        // randomized traffic against an occupancy/FIFO reference
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit acc, pop;
            check("rnd.valid64", {63'b0, vld64}, {63'b0, q64.size() > 0});
            check("rnd.ready64", {63'b0, rdy64}, {63'b0, q64.size() < 2});
            check("rnd.valid32", {63'b0, vld32}, {63'b0, q32.size() > 0});
            check("rnd.ready32", {63'b0, rdy32}, {63'b0, q32.size() < 2});
            if (q64.size() > 0)
                check_out("rnd", q64[0][63:0], q64[0][64], q32[0][31:0], q32[0][64]);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_instr  = $urandom;
            in_fmt    = 3'($urandom_range(0, 7));
            acc = in_valid && (q64.size() < 2);
            pop = out_ready && (q64.size() > 0);
            if (pop) begin
                void'(q64.pop_front());
                void'(q32.pop_front());
            end
            if (acc) begin
                q64.push_back(ref_model(in_instr, in_fmt, 64));
                q32.push_back(ref_model(in_instr, in_fmt, 32));
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
